// File: rtl/cache_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_adapter
// Description : Bridges a cache datapath to a burst-oriented memory port.
//               Read bursts assemble num_beats narrow beats into a full
//               line register (line_o). Write bursts stream a buffered line
//               out beat by beat, lowest address first.
// Ports       : clk, rst (sync, active-high)
//               cache side : addr_i, read_i, write_i, line_i -> line_o,
//                            resp_o, err_o
//               memory side: mem_addr_o, mem_read_o, mem_write_o,
//                            mem_wdata_o <- mem_rdata_i, mem_resp_i
// Options     : CACHE_LINE_ADAPTER_TIMEOUT_EN - per-beat idle timeout that
//               aborts a stuck burst and pulses err_o with resp_o.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_adapter #(
    parameter int s_offset       = 5,
    parameter int s_line         = 8 * 2**s_offset,
    parameter int s_beat         = 64,
    parameter int num_beats      = s_line / s_beat,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    output logic              resp_o,
    output logic              err_o,
    output logic [31:0]       mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [s_beat-1:0] mem_wdata_o,
    input  logic [s_beat-1:0] mem_rdata_i,
    input  logic              mem_resp_i
);

    localparam int BEAT_W = (num_beats > 1) ? $clog2(num_beats) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31-s_offset:0]  r_addr_hi;
    logic [s_line-1:0]     r_wbuf;
    logic [s_line-1:0]     r_line;
    logic [BEAT_W-1:0]     r_beat;
    logic                  w_last;
    logic                  w_busy;
    logic                  w_timeout;
    logic                  w_unused;

    assign w_last     = (r_beat == BEAT_W'(num_beats - 1));
    assign w_busy     = (r_state == READ) || (r_state == WRITE);
    assign line_o     = r_line;
    assign mem_addr_o = {r_addr_hi, {s_offset{1'b0}}};

    // Byte-offset bits of the request address never reach memory.
    assign w_unused   = ^{addr_i[s_offset-1:0], (TIMEOUT_CYCLES > 0)};

`ifdef CACHE_LINE_ADAPTER_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    // Abort on the cycle the counter would step onto TIMEOUT_CYCLES.
    assign w_timeout = w_busy && !mem_resp_i &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            // Cleared on every state entry and every accepted beat.
            if ((w_next != r_state) || mem_resp_i) begin
                r_tmo_cnt <= '0;
            end else if (w_busy) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (r_state == IDLE) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory-side outputs, decoded from registered state
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_wdata_o = '0;
        resp_o      = 1'b0;
        err_o       = 1'b0;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_next = WRITE;
                end else if (read_i) begin
                    w_next = READ;
                end
            end
            READ: begin
                mem_read_o = 1'b1;
                if ((mem_resp_i && w_last) || w_timeout) begin
                    w_next = DONE;
                end
            end
            WRITE: begin
                mem_write_o = 1'b1;
                mem_wdata_o = r_wbuf[s_beat*int'(r_beat) +: s_beat];
                if ((mem_resp_i && w_last) || w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                resp_o = 1'b1;
`ifdef CACHE_LINE_ADAPTER_TIMEOUT_EN
                err_o  = r_err;
`endif
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request capture, beat counter, line assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_hi <= '0;
            r_wbuf    <= '0;
            r_line    <= '0;
            r_beat    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_i) begin
                        r_wbuf    <= line_i;
                        r_addr_hi <= addr_i[31:s_offset];
                        r_beat    <= '0;
                    end else if (read_i) begin
                        r_addr_hi <= addr_i[31:s_offset];
                        r_beat    <= '0;
                    end
                end
                READ: begin
                    if (mem_resp_i) begin
                        r_line[s_beat*int'(r_beat) +: s_beat] <= mem_rdata_i;
                        r_beat <= w_last ? '0 : r_beat + 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_resp_i) begin
                        r_beat <= w_last ? '0 : r_beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_line_adapter
// Description : Scoreboard bench for cache_line_adapter. Stimulus queues the
//               expected completion (line, err flag, cycle) and write beats;
//               a negedge monitor pops and compares as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_adapter;

    localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic         err_o;
    logic [31:0]  mem_addr_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [63:0]  mem_wdata_o;
    logic [63:0]  mem_rdata_i;
    logic         mem_resp_i;

    cache_line_adapter #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .read_i     (read_i),
        .write_i    (write_i),
        .line_i     (line_i),
        .line_o     (line_o),
        .resp_o     (resp_o),
        .err_o      (err_o),
        .mem_addr_o (mem_addr_o),
        .mem_read_o (mem_read_o),
        .mem_write_o(mem_write_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_resp_i (mem_resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] line;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    logic [63:0]  wq[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [31:0]  exp_addr = '0;
    int           exp_mode = 0;      // 0 none, 1 read burst, 2 write burst
    logic [255:0] model_line = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_o) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 256'd1, 256'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_cycle", 256'(cyc), 256'(e.cyc));
                    chk("resp_err", {255'd0, err_o}, {255'd0, e.err});
                    chk("resp_line", line_o, e.line);
                end
            end else if (err_o) begin
                chk("err_without_resp", 256'd1, 256'd0);
            end
            if (mem_read_o || mem_write_o) begin
                chk("mem_addr", {224'd0, mem_addr_o}, {224'd0, exp_addr});
                chk("req_exclusive", {255'd0, mem_read_o & mem_write_o}, 256'd0);
            end
            if (mem_read_o) begin
                chk("read_when_not_read_burst", 256'(exp_mode), 256'd1);
            end
            if (mem_write_o) begin
                chk("write_when_not_write_burst", 256'(exp_mode), 256'd2);
                if (wq.size() == 0) begin
                    chk("extra_write_beat", 256'd1, 256'd0);
                end else begin
                    chk("mem_wdata", {192'd0, mem_wdata_o}, {192'd0, wq[0]});
                    if (mem_resp_i) void'(wq.pop_front());
                end
            end
        end
    end

    // One request from IDLE through DONE. pat[i] is mem_resp_i in burst
    // cycle i (after 'lead' leading idle cycles); beats come from rbeats.
    task automatic burst(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] ea, input logic [255:0] wl,
                         input logic [255:0] rbeats, input logic [15:0] pat,
                         input int plen, input int lead, input logic eerr);
        exp_t         e;
        logic [255:0] tmp;
        int           k;
        tmp = model_line;
        k   = 0;
        for (int i = 0; i < plen; i++) begin
            if (pat[i] && k < 4) begin
                if (rd && !wr) tmp[64*k +: 64] = rbeats[64*k +: 64];
                k++;
            end
        end
        e.line = tmp;
        e.err  = eerr;
        e.cyc  = cyc + 1 + lead + plen;
        sbq.push_back(e);
        model_line = tmp;
        exp_addr   = ea;
        exp_mode   = wr ? 2 : 1;
        if (wr) for (int j = 0; j < 4; j++) wq.push_back(wl[64*j +: 64]);
        addr_i     = a;
        read_i     = rd;
        write_i    = wr;
        line_i     = wl;
        mem_resp_i = 1'b0;
        @(posedge clk) #1;
        line_i = ~wl;                  // must already be captured
        repeat (lead) @(posedge clk) #1;
        k = 0;
        for (int i = 0; i < plen; i++) begin
            mem_resp_i  = pat[i];
            mem_rdata_i = (pat[i] && k < 4) ? rbeats[64*k +: 64] : BAD;
            if (pat[i]) k++;
            @(posedge clk) #1;
        end
        // DONE cycle: drop the request; a stray response must be ignored.
        read_i      = 1'b0;
        write_i     = 1'b0;
        mem_resp_i  = 1'b1;
        mem_rdata_i = BAD;
        @(posedge clk) #1;
        mem_resp_i = 1'b0;
        exp_mode   = 0;
    endtask

    localparam logic [255:0] FILL1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WLINE = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                                      64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
    localparam logic [255:0] WLINE2 = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    localparam logic [255:0] FILL2 = {64'h8888_0000_0000_0004, 64'h7777_0000_0000_0003,
                                      64'h6666_0000_0000_0002, 64'h5555_0000_0000_0001};

    initial begin
        logic [255:0] partial;
        rst = 1'b1; addr_i = '0; read_i = 1'b0; write_i = 1'b0; line_i = '0;
        mem_rdata_i = '0; mem_resp_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_line_o", line_o, 256'd0);
        chk("rst_resp_o", {255'd0, resp_o}, 256'd0);
        chk("rst_err_o", {255'd0, err_o}, 256'd0);
        chk("rst_mem_read_o", {255'd0, mem_read_o}, 256'd0);
        chk("rst_mem_write_o", {255'd0, mem_write_o}, 256'd0);
        chk("rst_mem_wdata_o", {192'd0, mem_wdata_o}, 256'd0);
        chk("rst_mem_addr_o", {224'd0, mem_addr_o}, 256'd0);
        rst = 1'b0;
        @(posedge clk) #1;

        // Fill with back-to-back responses
        burst(1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, '0, FILL1, 16'b1111, 4, 0, 1'b0);
        chk("fill1_line", line_o, FILL1);

        // Writeback with stalls 1,0,0,1,1,0,1
        burst(1'b0, 1'b1, 32'h0000_8F1C, 32'h0000_8F00, WLINE, '0, 16'b1011001, 7, 0, 1'b0);
        chk("line_after_write", line_o, FILL1);

        // Simultaneous read and write: write wins
        burst(1'b1, 1'b1, 32'hABCD_EF7F, 32'hABCD_EF60, WLINE2, FILL2, 16'b1111, 4, 0, 1'b0);

        // Reset after two read beats
        exp_addr = 32'h0000_2040; exp_mode = 1;
        addr_i = 32'h0000_2044; read_i = 1'b1;
        @(posedge clk) #1;
        mem_resp_i = 1'b1; mem_rdata_i = 64'hCAFE_0000_0000_0000;
        @(posedge clk) #1;
        mem_rdata_i = 64'hCAFE_0000_0000_0001;
        @(posedge clk) #1;
        mem_resp_i = 1'b0;
        partial = {FILL1[255:128], 64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
        chk("partial_line", line_o, partial);
        rst = 1'b1; read_i = 1'b0;
        @(posedge clk) #1;
        chk("midrst_line_o", line_o, 256'd0);
        chk("midrst_mem_read_o", {255'd0, mem_read_o}, 256'd0);
        chk("midrst_resp_o", {255'd0, resp_o}, 256'd0);
        rst = 1'b0; exp_mode = 0; model_line = '0;
        @(posedge clk) #1;

        // Fill after reset with a stall
        burst(1'b1, 1'b0, 32'h0000_3000, 32'h0000_3000, '0, FILL2, 16'b11011, 5, 0, 1'b0);
        chk("fill2_line", line_o, FILL2);

`ifdef CACHE_LINE_ADAPTER_TIMEOUT_EN
        // No responses: abort 9 cycles after acceptance, line_o kept
        burst(1'b1, 1'b0, 32'h0000_4000, 32'h0000_4000, '0, FILL1, 16'b0, 8, 0, 1'b1);
        chk("timeout_line", line_o, FILL2);
        burst(1'b1, 1'b0, 32'h0000_5020, 32'h0000_5020, '0, FILL1, 16'b1111, 4, 0, 1'b0);
`else
        // No responses for 1000 cycles: the burst must still be waiting
        burst(1'b1, 1'b0, 32'h0000_4000, 32'h0000_4000, '0, FILL1, 16'b1111, 4, 1000, 1'b0);
`endif
        chk("final_line", line_o, FILL1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 256'(sbq.size()), 256'd0);
        chk("wq_drained", 256'(wq.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
